output_drain: RTL and testbench
===============================

Name: output_drain

Overview:
- Reader for the output buffer. The accelerator controller fills this buffer during OUTPUT and then pulses run_finish.
- This block drains DEPTH words from OADDR onward and streams them to the host over a valid/ready interface.
- It is the only block that reads the output buffer. Read-port arbitration against the controller is done outside this block.

Parameters:
- ADDR_W, 6, output buffer address width.
- DATA_W, 32, output buffer word width.
- DEPTH, 30, words drained per run (1..2**ADDR_W).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-low reset.
- EN  in  1  global enable. When low, all state and outputs hold.
- START  in  1  one-cycle drain request (connect to controller run_finish).
- OADDR  in  ADDR_W  base address, sampled on accepted START.
- output_wen  out  1  buffer write-enable, active-low. Always 1 (read-only).
- output_ren  out  1  buffer read-enable, active-high.
- output_cen  out  1  buffer chip-enable, active-low.
- output_addr  out  ADDR_W  buffer address.
- output_rdata  in  DATA_W  buffer read data, valid one cycle after the cen=0 cycle.
- M_VALID  out  1  host data valid.
- M_READY  in  1  host ready.
- M_DATA  out  DATA_W  host data.
- M_LAST  out  1  marks the final word of a drain.
- BUSY  out  1  high in any state other than IDLE.
- DRAIN_DONE  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset is synchronous: RESET low at a rising edge loads reset values, whatever the state.
- Reset values:
  - state=IDLE
  - output_wen=1, output_ren=0, output_cen=1, output_addr=0
  - M_VALID=0, M_DATA=0, M_LAST=0, BUSY=0, DRAIN_DONE=0
  - word counter cnt=0
- Reset mid-drain aborts the drain with no DRAIN_DONE.
- EN=0: registers hold. This includes M_VALID and DRAIN_DONE, so a pulse stretches while EN is low. Handshakes occur only when EN=1.
- States: IDLE, RD, CAP, SEND, DONE. All outputs are registered.
- IDLE:
  - On START=1 (with EN=1): output_addr<=OADDR, output_cen<=0, output_ren<=1, cnt<=0, go to RD.
  - On START=0: output_cen=1, output_ren=0.
- RD: the buffer samples the address this cycle. output_cen<=1, output_ren<=0, go to CAP.
- CAP:
  - M_DATA<=output_rdata, M_VALID<=1.
  - M_LAST<=(cnt==DEPTH-1).
  - Go to SEND.
- SEND:
  - M_DATA and M_LAST stay stable while M_VALID=1 and M_READY=0.
  - On M_READY=1 with last word: M_VALID<=0, M_LAST<=0, go to DONE.
  - On M_READY=1 otherwise: M_VALID<=0, cnt<=cnt+1, output_addr<=output_addr+1, output_cen<=0, output_ren<=1, go to RD.
- DONE: DRAIN_DONE<=1 for exactly one cycle, then go to IDLE (DRAIN_DONE<=0).
- Latency: START in cycle 0, output_cen=0 in cycle 1, M_VALID=1 in cycle 3.
- Throughput: one word per 3 cycles when M_READY is held high.
- Address arithmetic is ADDR_W-bit modulo. OADDR+k wraps past 2**ADDR_W-1 to 0.
- START while BUSY=1 is ignored; no queuing.
- START on the DONE cycle is ignored. START on the cycle after DONE, when state is IDLE, is accepted.
- DEPTH=1: the single word carries M_LAST=1.
- output_wen is never driven 0.

Decomposition:
- Shared package (accel_pkg):
  - state encodings
  - buffer control constants: CEN_ON=0, CEN_OFF=1, WEN_RD=1, REN_ON=1, REN_OFF=0
  - ADDR_W default
- The package is reused by controller and by the buffer wrappers.
- No sub-module. This is a single FSM with counter, about 150 lines.

Test Plan:
- Basic drain: buffer preloaded with mem[k]=k+100, OADDR=8, DEPTH=30, M_READY=1, START pulse.
  - Expect 30 handshakes with data 108..137.
  - output_addr sequence 8..37.
  - M_LAST only on word 30.
  - DRAIN_DONE exactly 1 cycle, 2 cycles after the last handshake.
- Backpressure: M_READY low for 5 cycles on word 3.
  - M_VALID and M_DATA hold.
  - No new output_cen=0 pulse until the handshake.
  - Data order is intact.
- Wrap: OADDR=50, DEPTH=30.
  - Addresses 50..63 then 0..15.
  - Data matches mem at the wrapped addresses.
- START while busy: pulse START at word 10 with a different OADDR.
  - Ignored; the drain completes from the original base.
  - A new START after DRAIN_DONE starts a fresh drain.
- Reset mid-drain: RESET low at word 12.
  - Next edge: all outputs at reset values, state IDLE, no DRAIN_DONE.
- EN freeze and DEPTH=1:
  - EN low 4 cycles during CAP: nothing advances; resumes on EN high.
  - Separate build with DEPTH=1: a single word with M_LAST=1.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: FSM state encoding and buffer control levels.
package accel_pkg;

  localparam int unsigned ACCEL_ADDR_W = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  // Buffer strobes: cen/wen are active-low, ren is active-high.
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic WEN_RD  = 1'b1;
  localparam logic REN_ON  = 1'b1;
  localparam logic REN_OFF = 1'b0;

endpackage

// File: rtl/output_drain.sv
// Drains DEPTH words from the output buffer starting at OADDR and streams them
// to the host over valid/ready, one word per read/capture/send round.
module output_drain
  import accel_pkg::*;
#(
  parameter int unsigned ADDR_W = ACCEL_ADDR_W,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 30
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              START,
  input  logic [ADDR_W-1:0] OADDR,
  output logic              output_wen,
  output logic              output_ren,
  output logic              output_cen,
  output logic [ADDR_W-1:0] output_addr,
  input  logic [DATA_W-1:0] output_rdata,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_LAST,
  output logic              BUSY,
  output logic              DRAIN_DONE
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              ren_d, cen_d, valid_d, last_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  // The buffer is read-only from this side.
  assign output_wen = WEN_RD;

  // State and all output registers; EN low freezes everything.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      output_ren  <= REN_OFF;
      output_cen  <= CEN_OFF;
      output_addr <= '0;
      M_VALID     <= 1'b0;
      M_DATA      <= '0;
      M_LAST      <= 1'b0;
      BUSY        <= 1'b0;
      DRAIN_DONE  <= 1'b0;
    end else if (EN) begin
      state       <= state_nxt;
      cnt         <= cnt_d;
      output_ren  <= ren_d;
      output_cen  <= cen_d;
      output_addr <= addr_d;
      M_VALID     <= valid_d;
      M_DATA      <= data_d;
      M_LAST      <= last_d;
      BUSY        <= busy_d;
      DRAIN_DONE  <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START) state_nxt = RD;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = SEND;
      SEND:    if (M_READY) state_nxt = M_LAST ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt;
    ren_d   = output_ren;
    cen_d   = output_cen;
    addr_d  = output_addr;
    valid_d = M_VALID;
    data_d  = M_DATA;
    last_d  = M_LAST;
    done_d  = DRAIN_DONE;
    unique case (state)
      IDLE: begin
        done_d = 1'b0;
        if (START) begin
          addr_d = OADDR;
          cen_d  = CEN_ON;
          ren_d  = REN_ON;
          cnt_d  = '0;
        end else begin
          cen_d = CEN_OFF;
          ren_d = REN_OFF;
        end
      end
      RD: begin
        cen_d = CEN_OFF;
        ren_d = REN_OFF;
      end
      CAP: begin
        data_d  = output_rdata;
        valid_d = 1'b1;
        last_d  = (cnt == LAST_CNT);
      end
      SEND: begin
        if (M_READY) begin
          valid_d = 1'b0;
          if (M_LAST) begin
            last_d = 1'b0;
          end else begin
            // Address wraps modulo 2**ADDR_W by plain overflow.
            cnt_d  = cnt + CNT_W'(1);
            addr_d = output_addr + ADDR_W'(1);
            cen_d  = CEN_ON;
            ren_d  = REN_ON;
          end
        end
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_output_drain.sv
// Self-checking bench for output_drain: directed scenarios plus randomized
// drains checked against an address/data list computed from the buffer model.
module tb_output_drain;

  localparam int DEPTH0 = 30;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        EN = 1'b1;
  logic        START = 1'b0;
  logic [5:0]  OADDR = '0;
  logic        M_READY = 1'b0;
  logic        output_wen, output_ren, output_cen;
  logic [5:0]  output_addr;
  logic [31:0] output_rdata;
  logic        M_VALID, M_LAST, BUSY, DRAIN_DONE;
  logic [31:0] M_DATA;

  logic        start1 = 1'b0;
  logic [5:0]  oaddr1 = '0;
  logic        rdy1 = 1'b0;
  logic        wen1, ren1, cen1, valid1, last1, busy1, done1;
  logic [5:0]  addr1;
  logic [31:0] rdata1, data1;

  logic [31:0] mem [64];

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  output_drain #(.ADDR_W(6), .DATA_W(32), .DEPTH(DEPTH0)) u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .START(START), .OADDR(OADDR),
    .output_wen(output_wen), .output_ren(output_ren), .output_cen(output_cen),
    .output_addr(output_addr), .output_rdata(output_rdata),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_LAST(M_LAST),
    .BUSY(BUSY), .DRAIN_DONE(DRAIN_DONE)
  );

  output_drain #(.ADDR_W(6), .DATA_W(32), .DEPTH(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .START(start1), .OADDR(oaddr1),
    .output_wen(wen1), .output_ren(ren1), .output_cen(cen1),
    .output_addr(addr1), .output_rdata(rdata1),
    .M_VALID(valid1), .M_READY(rdy1), .M_DATA(data1), .M_LAST(last1),
    .BUSY(busy1), .DRAIN_DONE(done1)
  );

  // Synchronous-read buffer: data appears the cycle after cen is low.
  always @(posedge CLK) if (output_cen == 1'b0) output_rdata <= mem[output_addr];
  always @(posedge CLK) if (cen1 == 1'b0) rdata1 <= mem[addr1];

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready low 5 cycles on word 3.
  // done_start: 1 pulse START on the DONE cycle, 2 on the DRAIN_DONE cycle.
  task automatic run_drain(input logic [5:0] base, input int mode, input int busy_word,
                           input bit freeze, input int done_start,
                           input logic [5:0] chain_base, input bit pre_started);
    logic [5:0]  eaddr [$];
    logic [31:0] edata [$];
    int nhs = 0, nreads = 0, s = 0, hs_s = -10, bp = 0;
    bit prev_pending = 0, freeze_next = 0, busy_done = 0, finished = 0;
    logic [31:0] sd;
    logic [5:0]  sa;
    logic        sv, sc, sb;

    for (int k = 0; k < DEPTH0; k++) begin
      eaddr.push_back(base + 6'(k));
      edata.push_back(mem[base + 6'(k)]);
    end
    if (!pre_started) begin
      START = 1'b1;
      OADDR = base;
      step();
      START = 1'b0;
      OADDR = 6'($urandom);
    end
    check("busy_after_start", BUSY, 1'b1);

    while (!finished && s < 2000) begin
      if (freeze_next) begin
        freeze_next = 0;
        sd = M_DATA; sa = output_addr; sv = M_VALID; sc = output_cen; sb = BUSY;
        EN = 1'b0;
        repeat (4) begin
          step();
          check("freeze_valid", M_VALID, sv);
          check("freeze_data", M_DATA, sd);
          check("freeze_addr", output_addr, sa);
          check("freeze_cen", output_cen, sc);
          check("freeze_busy", BUSY, sb);
        end
        EN = 1'b1;
      end

      case (mode)
        0: M_READY = 1'b1;
        1: M_READY = ($urandom_range(0, 3) != 0);
        default: begin
          M_READY = !(M_VALID && nhs == 2 && bp < 5);
          if (!M_READY) bp++;
        end
      endcase

      START = 1'b0;
      if (busy_word >= 0 && !busy_done && M_VALID && nhs == busy_word) begin
        START = 1'b1;
        OADDR = base ^ 6'h15;
        busy_done = 1;
      end
      if (done_start == 1 && nhs == DEPTH0 && s == hs_s + 1) begin
        START = 1'b1;
        OADDR = chain_base;
      end
      if (done_start == 2 && DRAIN_DONE) begin
        START = 1'b1;
        OADDR = chain_base;
      end

      check("wen_high", output_wen, 1'b1);
      if (output_cen == 1'b0) begin
        check("rd_addr", output_addr, eaddr[nreads]);
        check("rd_order", 64'(nreads), 64'(nhs));
        check("rd_ren", output_ren, 1'b1);
        if (freeze && nreads == 3) freeze_next = 1;
        nreads++;
      end
      if (prev_pending) check("valid_hold", M_VALID, 1'b1);
      if (M_VALID) begin
        check("m_data", M_DATA, edata[nhs]);
        check("m_last", M_LAST, (nhs == DEPTH0 - 1));
      end
      if (DRAIN_DONE) begin
        check("done_latency", 64'(s - hs_s), 64'd2);
        check("done_words", 64'(nhs), 64'(DEPTH0));
        check("done_busy", BUSY, 1'b0);
        finished = 1;
      end else begin
        check("busy_during", BUSY, 1'b1);
      end

      prev_pending = M_VALID && !(M_READY && EN);
      if (M_VALID && M_READY && EN) begin
        nhs++;
        hs_s = s;
      end
      step();
      s++;
    end
    START = 1'b0;

    if (!finished) begin
      check("drain_timeout", 64'd0, 64'd1);
    end else begin
      check("done_pulse_end", DRAIN_DONE, 1'b0);
      check("valid_after", M_VALID, 1'b0);
      if (done_start == 2) begin
        check("chain_cen", output_cen, 1'b0);
        check("chain_addr", output_addr, chain_base);
        check("chain_busy", BUSY, 1'b1);
      end else begin
        check("idle_busy", BUSY, 1'b0);
        check("idle_cen", output_cen, 1'b1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"}, output_wen, 1'b1);
    check({tag, "_ren"}, output_ren, 1'b0);
    check({tag, "_cen"}, output_cen, 1'b1);
    check({tag, "_addr"}, output_addr, 6'd0);
    check({tag, "_valid"}, M_VALID, 1'b0);
    check({tag, "_data"}, M_DATA, 32'd0);
    check({tag, "_last"}, M_LAST, 1'b0);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_done"}, DRAIN_DONE, 1'b0);
  endtask

  initial begin
    int nhs;
    int guard;

    for (int k = 0; k < 64; k++) mem[k] = 32'(k + 100);

    // Reset state, then idle with no START.
    RESET = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    RESET = 1'b1;
    repeat (3) step();
    check("idle_cen_hold", output_cen, 1'b1);
    check("idle_busy_hold", BUSY, 1'b0);

    // Latency: START cycle 0, cen low cycle 1, M_VALID cycle 3.
    START = 1'b1;
    OADDR = 6'd8;
    M_READY = 1'b1;
    step();
    START = 1'b0;
    check("lat_cen_c1", output_cen, 1'b0);
    step();
    check("lat_valid_c2", M_VALID, 1'b0);
    step();
    check("lat_valid_c3", M_VALID, 1'b1);
    check("lat_data_c3", M_DATA, 32'd108);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    step();

    run_drain(6'd8, 0, -1, 0, 0, 6'd0, 0);    // basic
    run_drain(6'd8, 2, -1, 0, 0, 6'd0, 0);    // backpressure on word 3
    run_drain(6'd50, 0, -1, 0, 0, 6'd0, 0);   // wrap
    run_drain(6'd4, 0, 9, 0, 2, 6'd20, 0);    // START while busy, restart on done
    run_drain(6'd20, 1, -1, 0, 1, 6'd40, 1);  // START on DONE cycle ignored
    run_drain(6'd12, 0, -1, 1, 0, 6'd0, 0);   // EN freeze in CAP

    // Reset mid-drain at word 12.
    START = 1'b1;
    OADDR = 6'd30;
    M_READY = 1'b1;
    step();
    START = 1'b0;
    nhs = 0;
    guard = 0;
    while (!(M_VALID && nhs == 11) && guard < 500) begin
      if (M_VALID) nhs++;
      step();
      guard++;
    end
    check("reset_reach_w12", 64'(nhs), 64'd11);
    RESET = 1'b0;
    step();
    check_reset_outputs("midreset");
    RESET = 1'b1;
    repeat (6) begin
      step();
      check("midreset_no_done", DRAIN_DONE, 1'b0);
      check("midreset_idle", BUSY, 1'b0);
    end

    // Randomized drains over random buffer contents.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 64; k++) mem[k] = $urandom;
      run_drain(6'($urandom), 1, -1, 0, 0, 6'd0, 0);
    end

    // DEPTH=1 build: one word carrying M_LAST.
    oaddr1 = 6'd33;
    rdy1 = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("d1_cen", cen1, 1'b0);
    check("d1_addr", addr1, 6'd33);
    step();
    step();
    check("d1_valid", valid1, 1'b1);
    check("d1_last", last1, 1'b1);
    check("d1_data", data1, mem[33]);
    step();
    check("d1_valid_drop", valid1, 1'b0);
    step();
    check("d1_done", done1, 1'b1);
    step();
    check("d1_done_end", done1, 1'b0);
    check("d1_idle", busy1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
